trap_entry_unit: RTL and testbench

Consumes trap causes encoded per the core's `rv_trap_t` exception/interrupt codes and turns them into an architectural machine-mode trap entry. It arbitrates the commit-head exception against pending interrupts, updates `mcause`/`mepc`/`mtval`, flushes the pipeline and issues the fetch redirect to the trap vector. It sits between the ROB commit stage and the CSR file / frontend redirect path.

---
 rtl/trap_entry_unit.sv | 148 ++++++++++++++
 tb/tb_trap_entry_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_entry_unit.sv
// Machine-mode trap entry: arbitrates commit-head exceptions against pending
// interrupts, produces mcause/mepc/mtval, a flush pulse and the trap-vector redirect.
module trap_entry_unit #(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned TRAPCODE_WIDTH = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_exc_vld,
  output logic                      o_exc_rdy,
  input  logic [TRAPCODE_WIDTH-1:0] i_exc_code,
  input  logic [XLEN-1:0]           i_exc_pc,
  input  logic [XLEN-1:0]           i_exc_tval,
  input  logic [7:0]                i_exc_robIdx,
  input  logic                      i_commit_vld,
  input  logic [XLEN-1:0]           i_commit_pc,
  input  logic [15:0]               i_irq_pending,
  input  logic [15:0]               i_irq_enable,
  input  logic                      i_mstatus_mie,
  input  logic [XLEN-1:0]           i_mtvec,
  output logic                      o_csr_we,
  output logic [XLEN-1:0]           o_mcause,
  output logic [XLEN-1:0]           o_mepc,
  output logic [XLEN-1:0]           o_mtval,
  output logic                      o_flush,
  output logic [7:0]                o_flush_robIdx,
  output logic                      o_redirect_vld,
  output logic [XLEN-1:0]           o_redirect_pc,
  input  logic                      i_redirect_rdy,
  output logic                      o_busy,
  output logic [CNT_WIDTH-1:0]      o_trap_cnt
);

  localparam int unsigned IRQ_W    = 16;
  localparam int unsigned ROB_W    = 8;
  // Only the standard machine/supervisor software, timer and external lines trap.
  localparam logic [IRQ_W-1:0] IRQ_MASK = 16'h0AAA;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRCSR    = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [XLEN-1:0]          mcause_q, mcause_d;
  logic [XLEN-1:0]          mepc_q, mepc_d;
  logic [XLEN-1:0]          mtval_q, mtval_d;
  logic [ROB_W-1:0]         rob_q, rob_d;
  logic [XLEN-1:0]          redir_pc_q, redir_pc_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

  logic [IRQ_W-1:0]          irq_elig;
  logic                      irq_hit;
  logic [TRAPCODE_WIDTH-1:0] irq_code;
  logic                      take_irq;
  logic [TRAPCODE_WIDTH-1:0] take_code;
  logic [XLEN-1:0]           vec_base;

  // Interrupt selection, fixed priority 11 > 3 > 7 > 9 > 1 > 5
  always_comb begin
    irq_elig = i_irq_pending & i_irq_enable & IRQ_MASK;
    irq_hit  = i_mstatus_mie & i_commit_vld & (|irq_elig);
    irq_code = '0;
    if (irq_elig[11])     irq_code = TRAPCODE_WIDTH'(11);
    else if (irq_elig[3]) irq_code = TRAPCODE_WIDTH'(3);
    else if (irq_elig[7]) irq_code = TRAPCODE_WIDTH'(7);
    else if (irq_elig[9]) irq_code = TRAPCODE_WIDTH'(9);
    else if (irq_elig[1]) irq_code = TRAPCODE_WIDTH'(1);
    else if (irq_elig[5]) irq_code = TRAPCODE_WIDTH'(5);
  end

  assign take_irq  = ~i_exc_vld & irq_hit;
  assign take_code = i_exc_vld ? i_exc_code : irq_code;
  assign vec_base  = {i_mtvec[XLEN-1:2], 2'b00};

  // Next-state and capture logic
  always_comb begin
    state_d    = state_q;
    mcause_d   = mcause_q;
    mepc_d     = mepc_q;
    mtval_d    = mtval_q;
    rob_d      = rob_q;
    redir_pc_d = redir_pc_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_exc_vld || irq_hit) begin
          state_d  = WRCSR;
          cnt_d    = cnt_q + CNT_WIDTH'(1);
          mcause_d = XLEN'(take_code);
          mcause_d[XLEN-1] = take_irq;
          if (take_irq) begin
            mepc_d  = {i_commit_pc[XLEN-1:1], 1'b0};
            mtval_d = '0;
            rob_d   = '0;
          end else begin
            mepc_d  = {i_exc_pc[XLEN-1:1], 1'b0};
            mtval_d = i_exc_tval;
            rob_d   = i_exc_robIdx;
          end
          if (take_irq && (i_mtvec[1:0] == 2'b01))
            redir_pc_d = vec_base + (XLEN'(take_code) << 2);
          else
            redir_pc_d = vec_base;
        end
      end
      WRCSR:    state_d = REDIRECT;
      REDIRECT: if (i_redirect_rdy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mcause_q   <= '0;
      mepc_q     <= '0;
      mtval_q    <= '0;
      rob_q      <= '0;
      redir_pc_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mcause_q   <= mcause_d;
      mepc_q     <= mepc_d;
      mtval_q    <= mtval_d;
      rob_q      <= rob_d;
      redir_pc_q <= redir_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Strobes and status are pure decodes of the registered state
  assign o_exc_rdy      = (state_q == IDLE);
  assign o_busy         = (state_q != IDLE);
  assign o_csr_we       = (state_q == WRCSR);
  assign o_flush        = (state_q == WRCSR);
  assign o_redirect_vld = (state_q == REDIRECT);
  assign o_redirect_pc  = (state_q == REDIRECT) ? redir_pc_q : '0;
  assign o_mcause       = mcause_q;
  assign o_mepc         = mepc_q;
  assign o_mtval        = mtval_q;
  assign o_flush_robIdx = rob_q;
  assign o_trap_cnt     = cnt_q;

endmodule

// File: tb/tb_trap_entry_unit.sv
// Directed bench for trap_entry_unit: exception/interrupt entry, priority,
// vectoring, redirect backpressure and reset mid-trap.
module tb_trap_entry_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_exc_vld;
  logic        o_exc_rdy;
  logic [15:0] i_exc_code;
  logic [63:0] i_exc_pc;
  logic [63:0] i_exc_tval;
  logic [7:0]  i_exc_robIdx;
  logic        i_commit_vld;
  logic [63:0] i_commit_pc;
  logic [15:0] i_irq_pending;
  logic [15:0] i_irq_enable;
  logic        i_mstatus_mie;
  logic [63:0] i_mtvec;
  logic        o_csr_we;
  logic [63:0] o_mcause;
  logic [63:0] o_mepc;
  logic [63:0] o_mtval;
  logic        o_flush;
  logic [7:0]  o_flush_robIdx;
  logic        o_redirect_vld;
  logic [63:0] o_redirect_pc;
  logic        i_redirect_rdy;
  logic        o_busy;
  logic [31:0] o_trap_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  trap_entry_unit dut (
    .clk(clk), .rst(rst),
    .i_exc_vld(i_exc_vld), .o_exc_rdy(o_exc_rdy), .i_exc_code(i_exc_code),
    .i_exc_pc(i_exc_pc), .i_exc_tval(i_exc_tval), .i_exc_robIdx(i_exc_robIdx),
    .i_commit_vld(i_commit_vld), .i_commit_pc(i_commit_pc),
    .i_irq_pending(i_irq_pending), .i_irq_enable(i_irq_enable),
    .i_mstatus_mie(i_mstatus_mie), .i_mtvec(i_mtvec),
    .o_csr_we(o_csr_we), .o_mcause(o_mcause), .o_mepc(o_mepc), .o_mtval(o_mtval),
    .o_flush(o_flush), .o_flush_robIdx(o_flush_robIdx),
    .o_redirect_vld(o_redirect_vld), .o_redirect_pc(o_redirect_pc),
    .i_redirect_rdy(i_redirect_rdy), .o_busy(o_busy), .o_trap_cnt(o_trap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".exc_rdy"},  64'(o_exc_rdy), 64'd1);
    check({tag, ".busy"},     64'(o_busy), 64'd0);
    check({tag, ".csr_we"},   64'(o_csr_we), 64'd0);
    check({tag, ".flush"},    64'(o_flush), 64'd0);
    check({tag, ".rd_vld"},   64'(o_redirect_vld), 64'd0);
    check({tag, ".rd_pc"},    o_redirect_pc, 64'd0);
    check({tag, ".mcause"},   o_mcause, 64'd0);
    check({tag, ".mepc"},     o_mepc, 64'd0);
    check({tag, ".mtval"},    o_mtval, 64'd0);
    check({tag, ".rob"},      64'(o_flush_robIdx), 64'd0);
    check({tag, ".cnt"},      64'(o_trap_cnt), 64'd0);
  endtask

  task automatic set_exc(input logic [15:0] code, input logic [63:0] pc,
                         input logic [63:0] tval, input logic [7:0] rob);
    i_exc_vld = 1'b1; i_exc_code = code; i_exc_pc = pc;
    i_exc_tval = tval; i_exc_robIdx = rob;
  endtask

  initial begin
    rst = 1'b1; i_exc_vld = 1'b0; i_exc_code = '0; i_exc_pc = '0; i_exc_tval = '0;
    i_exc_robIdx = '0; i_commit_vld = 1'b0; i_commit_pc = '0; i_irq_pending = '0;
    i_irq_enable = '0; i_mstatus_mie = 1'b0; i_mtvec = '0; i_redirect_rdy = 1'b1;
    tick(); tick();
    check_reset_vals("reset");
    rst = 1'b0;

    // Exception in vectored mode: target is still the base
    i_mtvec = 64'h8000_1001;
    set_exc(16'd2, 64'h8000_0102, 64'h0000_FFFF, 8'h85);
    tick();
    i_exc_vld = 1'b0;
    check("e1.csr_we", 64'(o_csr_we), 64'd1);
    check("e1.flush",  64'(o_flush), 64'd1);
    check("e1.mcause", o_mcause, 64'h2);
    check("e1.mepc",   o_mepc, 64'h8000_0102);
    check("e1.mtval",  o_mtval, 64'hFFFF);
    check("e1.rob",    64'(o_flush_robIdx), 64'h85);
    check("e1.rdy",    64'(o_exc_rdy), 64'd0);
    check("e1.cnt",    64'(o_trap_cnt), 64'd1);
    tick();
    check("e1.csr_we2", 64'(o_csr_we), 64'd0);
    check("e1.rd_vld",  64'(o_redirect_vld), 64'd1);
    check("e1.rd_pc",   o_redirect_pc, 64'h8000_1000);
    tick();
    check("e1.idle",    64'(o_exc_rdy), 64'd1);
    check("e1.rd_off",  64'(o_redirect_vld), 64'd0);

    // Vectored interrupt, code 7
    i_irq_pending = 16'h0080; i_irq_enable = 16'h0080; i_mstatus_mie = 1'b1;
    i_commit_vld = 1'b1; i_commit_pc = 64'h8000_0200;
    tick();
    i_irq_pending = '0;
    check("i7.mcause", o_mcause, 64'h8000_0000_0000_0007);
    check("i7.mepc",   o_mepc, 64'h8000_0200);
    check("i7.mtval",  o_mtval, 64'd0);
    check("i7.rob",    64'(o_flush_robIdx), 64'd0);
    check("i7.cnt",    64'(o_trap_cnt), 64'd2);
    tick();
    check("i7.rd_pc",  o_redirect_pc, 64'h8000_101C);
    tick();

    // Exception beats pending interrupts; code 11 wins among 7/11/3 afterwards
    i_irq_pending = 16'h0888; i_irq_enable = 16'hFFFF;
    set_exc(16'd5, 64'h8000_0301, 64'h1234, 8'h07);
    tick();
    i_exc_vld = 1'b0;
    check("p.exc_mcause", o_mcause, 64'h5);
    check("p.exc_mepc",   o_mepc, 64'h8000_0300);
    tick();
    check("p.exc_rd_pc",  o_redirect_pc, 64'h8000_1000);
    tick();
    check("p.idle",       64'(o_exc_rdy), 64'd1);
    tick();
    i_irq_pending = '0;
    check("p.irq_mcause", o_mcause, 64'h8000_0000_0000_000B);
    check("p.cnt",        64'(o_trap_cnt), 64'd4);
    tick();
    check("p.irq_rd_pc",  o_redirect_pc, 64'h8000_102C);
    tick();

    // Mode 3 is treated as direct; 9 beats 1 and 5
    i_mtvec = 64'h8000_2003; i_irq_pending = 16'h0222;
    tick();
    i_irq_pending = '0;
    check("m3.mcause", o_mcause, 64'h8000_0000_0000_0009);
    tick();
    check("m3.rd_pc",  o_redirect_pc, 64'h8000_2000);
    tick();

    // Redirect backpressure with input churn
    rst = 1'b1; tick(); rst = 1'b0;
    i_mtvec = 64'h8000_1001; i_redirect_rdy = 1'b0;
    set_exc(16'd2, 64'h8000_0102, 64'h0000_FFFF, 8'h11);
    tick();
    i_exc_vld = 1'b0;
    tick();
    set_exc(16'd7, 64'h9000_0000, 64'h0, 8'h22);
    i_mtvec = 64'h1234_0000;
    for (int i = 0; i < 5; i++) begin
      check("bp.rd_vld", 64'(o_redirect_vld), 64'd1);
      check("bp.rd_pc",  o_redirect_pc, 64'h8000_1000);
      check("bp.rdy",    64'(o_exc_rdy), 64'd0);
      if (i == 4) begin i_redirect_rdy = 1'b1; i_exc_vld = 1'b0; end
      tick();
    end
    check("bp.idle",   64'(o_exc_rdy), 64'd1);
    check("bp.cnt",    64'(o_trap_cnt), 64'd1);
    check("bp.mcause", o_mcause, 64'h2);
    check("bp.rob",    64'(o_flush_robIdx), 64'h11);

    // Reset during WRCSR
    i_mtvec = 64'h8000_1001;
    set_exc(16'd1, 64'h8000_0400, 64'h0, 8'h33);
    tick();
    i_exc_vld = 1'b0; rst = 1'b1;
    check("rw.csr_we", 64'(o_csr_we), 64'd1);
    tick();
    rst = 1'b0;
    check_reset_vals("rw");
    tick();
    check("rw.no_rd", 64'(o_redirect_vld), 64'd0);

    // Reset during REDIRECT
    i_redirect_rdy = 1'b0;
    set_exc(16'd1, 64'h8000_0400, 64'h0, 8'h33);
    tick();
    i_exc_vld = 1'b0;
    tick();
    check("rr.rd_vld", 64'(o_redirect_vld), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; i_redirect_rdy = 1'b1;
    check_reset_vals("rr");

    // Eligibility gating: mie, commit boundary, ignored bits
    i_irq_pending = 16'h0008; i_irq_enable = 16'hFFFF;
    i_mstatus_mie = 1'b0; i_commit_vld = 1'b1;
    tick();
    check("g.mie0", 64'(o_busy), 64'd0);
    i_mstatus_mie = 1'b1; i_commit_vld = 1'b0;
    tick();
    check("g.cv0",  64'(o_busy), 64'd0);
    i_commit_vld = 1'b1; i_irq_pending = 16'h0001;
    tick();
    check("g.bit0", 64'(o_busy), 64'd0);
    check("g.cnt",  64'(o_trap_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
